// File: rtl/mem_ctrl.sv
// mem_ctrl -- arbiter and byte sequencer for the shared byte-wide synchronous RAM.
//
// Instruction fetch (IF) and the MEM stage share one RAM port. MEM has fixed
// priority. A granted access of 1..4 bytes is split into byte cycles. The
// assembled word is returned with a one-cycle done pulse to the owner. Every
// access then spends one DONE cycle before the next grant.
//
// Optional feature: define MEMCTRL_ABORT_EN to let if_abort_in cancel an
// IF-owned read and block an IF grant in IDLE.
//
// Ports:
//   clk_in, rst_in        clock and asynchronous active-high reset
//   rdy_in                global enable; low freezes state and masks strobes
//   if_req_in/if_addr_in  IF word-read request (held until if_done_out)
//   if_abort_in           IF flush (used only with MEMCTRL_ABORT_EN)
//   if_done_out/if_inst_out      IF completion pulse and fetched word
//   mem_req_in/we/len/addr/wdata MEM request (held until mem_done_out)
//   mem_done_out/mem_rdata_out   MEM completion pulse and zero-extended load data
//   ram_din_in            RAM read byte, valid the cycle after its address
//   ram_dout_out/ram_a_out/ram_wr_out  RAM write byte, address and write strobe
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  input  logic        if_abort_in,
  output logic        if_done_out,
  output logic [31:0] if_inst_out,
  input  logic        mem_req_in,
  input  logic        mem_we_in,
  input  logic [1:0]  mem_len_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_wdata_in,
  output logic        mem_done_out,
  output logic [31:0] mem_rdata_out,
  input  logic [7:0]  ram_din_in,
  output logic [7:0]  ram_dout_out,
  output logic [31:0] ram_a_out,
  output logic        ram_wr_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  state_t      r_state, w_state;
  logic [2:0]  r_cnt, w_cnt;           // next byte index to present
  logic [1:0]  r_ci, w_ci;             // next byte lane to capture
  logic        r_first, w_first;       // first READ cycle: no RAM data yet
  logic        r_owner_mem, w_owner_mem;
  logic        r_we, w_we;
  logic [1:0]  r_len, w_len;
  logic [31:0] r_base, w_base;
  logic [31:0] r_wdata, w_wdata;
  logic [31:0] r_rbuf, w_rbuf;
  logic [31:0] r_ram_a, w_ram_a;
  logic [7:0]  r_ram_dout, w_ram_dout;
  logic        r_ram_wr, w_ram_wr;
  logic        r_if_done, w_if_done;
  logic        r_mem_done, w_mem_done;
  logic [31:0] r_if_inst, w_if_inst;
  logic [31:0] r_mem_rdata, w_mem_rdata;
  logic [7:0]  r_hold_byte;
  logic        r_hold_vld;
  logic [7:0]  w_din;
  logic        w_abort;

`ifdef MEMCTRL_ABORT_EN
  assign w_abort = if_abort_in;
`else
  logic w_unused_abort;
  assign w_unused_abort = if_abort_in;
  assign w_abort        = 1'b0;
`endif

  // While stalled the held RAM address already points at the following byte,
  // so the byte that was in flight is parked here on the first stalled edge.
  assign w_din = r_hold_vld ? r_hold_byte : ram_din_in;

  assign if_inst_out   = r_if_inst;
  assign mem_rdata_out = r_mem_rdata;
  assign ram_a_out     = r_ram_a;
  assign ram_dout_out  = r_ram_dout;
  // Strobes are masked while rdy_in is low; the held DONE re-issues them afterwards.
  assign ram_wr_out    = r_ram_wr & rdy_in;
  assign if_done_out   = r_if_done & rdy_in;
  assign mem_done_out  = r_mem_done & rdy_in;

  // Park the in-flight read byte during a stall.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_hold_vld  <= 1'b0;
      r_hold_byte <= 8'h00;
    end else if (rdy_in) begin
      r_hold_vld  <= 1'b0;
    end else if (!r_hold_vld) begin
      r_hold_vld  <= 1'b1;
      r_hold_byte <= ram_din_in;
    end
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_ci        = r_ci;
    w_first     = r_first;
    w_owner_mem = r_owner_mem;
    w_we        = r_we;
    w_len       = r_len;
    w_base      = r_base;
    w_wdata     = r_wdata;
    w_rbuf      = r_rbuf;
    w_ram_a     = r_ram_a;
    w_ram_dout  = r_ram_dout;
    w_ram_wr    = 1'b0;
    w_if_done   = 1'b0;
    w_mem_done  = 1'b0;
    w_if_inst   = r_if_inst;
    w_mem_rdata = r_mem_rdata;
    case (r_state)
      IDLE: begin
        if (mem_req_in) begin
          w_owner_mem = 1'b1;
          w_we        = mem_we_in;
          w_len       = mem_len_in;
          w_base      = mem_addr_in;
          w_wdata     = mem_wdata_in;
          w_rbuf      = 32'h0000_0000;
          w_ram_a     = mem_addr_in;
          w_ram_dout  = mem_wdata_in[7:0];
          w_ram_wr    = mem_we_in;
          w_cnt       = 3'd1;
          w_ci        = 2'd0;
          w_first     = 1'b1;
          w_state     = mem_we_in ? WRITE : READ;
        end else if (if_req_in && !w_abort) begin
          w_owner_mem = 1'b0;
          w_we        = 1'b0;
          w_len       = 2'd3;
          w_base      = if_addr_in;
          w_rbuf      = 32'h0000_0000;
          w_ram_a     = if_addr_in;
          w_cnt       = 3'd1;
          w_ci        = 2'd0;
          w_first     = 1'b1;
          w_state     = READ;
        end else begin
          w_state     = IDLE;
        end
      end
      READ: begin
        if (w_abort && !r_owner_mem) begin
          w_state = IDLE;
        end else begin
          if (r_cnt <= {1'b0, r_len}) begin
            w_ram_a = r_base + {29'd0, r_cnt};
            w_cnt   = r_cnt + 3'd1;
          end else begin
            w_ram_a = r_ram_a;
          end
          if (r_first) begin
            w_first = 1'b0;
          end else begin
            w_rbuf[{r_ci, 3'b000} +: 8] = w_din;
            if (r_ci == r_len) begin
              w_state = DONE;
              if (r_owner_mem) begin
                w_mem_done  = 1'b1;
                w_mem_rdata = w_rbuf;
              end else begin
                w_if_done   = 1'b1;
                w_if_inst   = w_rbuf;
              end
            end else begin
              w_ci = r_ci + 2'd1;
            end
          end
        end
      end
      WRITE: begin
        if (r_cnt <= {1'b0, r_len}) begin
          w_ram_a    = r_base + {29'd0, r_cnt};
          w_ram_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
          w_ram_wr   = 1'b1;
          w_cnt      = r_cnt + 3'd1;
        end else begin
          w_mem_done = 1'b1;
          w_state    = DONE;
        end
      end
      DONE: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // State and output registers; everything holds while rdy_in is low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_cnt       <= 3'd0;
      r_ci        <= 2'd0;
      r_first     <= 1'b0;
      r_owner_mem <= 1'b0;
      r_we        <= 1'b0;
      r_len       <= 2'd0;
      r_base      <= 32'h0000_0000;
      r_wdata     <= 32'h0000_0000;
      r_rbuf      <= 32'h0000_0000;
      r_ram_a     <= 32'h0000_0000;
      r_ram_dout  <= 8'h00;
      r_ram_wr    <= 1'b0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_inst   <= 32'h0000_0000;
      r_mem_rdata <= 32'h0000_0000;
    end else if (rdy_in) begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_ci        <= w_ci;
      r_first     <= w_first;
      r_owner_mem <= w_owner_mem;
      r_we        <= w_we;
      r_len       <= w_len;
      r_base      <= w_base;
      r_wdata     <= w_wdata;
      r_rbuf      <= w_rbuf;
      r_ram_a     <= w_ram_a;
      r_ram_dout  <= w_ram_dout;
      r_ram_wr    <= w_ram_wr;
      r_if_done   <= w_if_done;
      r_mem_done  <= w_mem_done;
      r_if_inst   <= w_if_inst;
      r_mem_rdata <= w_mem_rdata;
    end
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Arbiter and sequencer for the single byte-wide synchronous RAM port. It is shared between instruction fetch (IF) and the MEM stage. The block serialises 1–4 byte accesses into byte cycles and returns the assembled word with a one-cycle done pulse. Stage logic turns "request pending, no done" into stall requests for the pipeline-register stall vector.

## Interface
No parameters.
- clk_in  input  1  system clock; all state changes on its rising edge
- rst_in  input  1  reset, asynchronous, active-high
- rdy_in  input  1  global enable; low freezes all state
- if_req_in  input  1  IF read request; held until if_done_out
- if_addr_in  input  32  IF fetch address; always a 4-byte read
- if_abort_in  input  1  IF flush (honoured only with MEMCTRL_ABORT_EN)
- if_done_out  output  1  one-cycle pulse; if_inst_out valid
- if_inst_out  output  32  fetched word, little-endian
- mem_req_in  input  1  MEM request; held until mem_done_out
- mem_we_in  input  1  1 = store, 0 = load
- mem_len_in  input  2  byte count minus 1 (0..3)
- mem_addr_in  input  32  base byte address
- mem_wdata_in  input  32  store data; byte k goes to addr+k
- mem_done_out  output  1  one-cycle completion pulse
- mem_rdata_out  output  32  load data, zero-extended; MEM stage applies sign extension
- ram_din_in  input  8  RAM read byte; valid the cycle after its address is presented
- ram_dout_out  output  8  RAM write byte
- ram_a_out  output  32  RAM byte address
- ram_wr_out  output  1  RAM write strobe

## Operation
- Reset values:
  - All outputs are 0.
  - State is IDLE; byte counter cnt is 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If mem_req_in is high, latch the MEM request (we, len, addr, wdata) and go to WRITE or READ.
  - Otherwise, if if_req_in is high, latch if_addr_in with len = 3 and go to READ.
  - MEM has fixed priority because it is the older instruction.
  - On grant, present base+0 on ram_a_out and set cnt = 1.
- READ:
  - Present addresses base+1 .. base+len on successive cycles.
  - Capture each arriving ram_din_in into byte lane (arrival index) of the data register; unused lanes are 0.
  - After capturing byte len, drive the owner's done pulse and data, then go to DONE.
  - ram_wr_out is 0 throughout READ.
- WRITE:
  - Each cycle drive ram_a_out = base+k, ram_dout_out = wdata[8k+7:8k] and ram_wr_out = 1, for k = 0..len.
  - After byte len, drop ram_wr_out, pulse mem_done_out and go to DONE.
- DONE:
  - Lasts exactly one cycle with done high; no grant is made.
  - Then return to IDLE, so a requester's register-driven req has time to fall.
- Data outputs hold their last value until the next completion for that requester.
- rdy_in low:
  - State, cnt, latched request and data outputs hold.
  - ram_wr_out is forced to 0.
  - Done pulses are suppressed and re-issued once rdy_in returns.
  - A read byte whose address was presented is still captured correctly (RAM address held).
- Address arithmetic is 32-bit and wraps modulo 2^32.
- Requests that change while granted are ignored; only the values latched at grant are used.
- Reset asserted mid-access aborts the access immediately: outputs go to 0 with no done pulse.

## Timing
- Edge E is the edge at which IDLE grants. N = len+1.
- Read: byte k is presented after edge E+k and captured at edge E+k+2. Done is high after edge E+N+1 (word: 5 edges, byte: 2).
- Write: byte k is written after edge E+k. Done is high after edge E+N.
- Idle gap: the next grant happens at the earliest at the edge after DONE. Back-to-back word reads therefore take 7 cycles each.
- Simultaneous IF and MEM requests in IDLE: MEM wins. IF waits, holding its request.

## Configuration
- MEMCTRL_ABORT_EN defined:
  - if_abort_in high during an IF-owned READ returns to IDLE at the next edge, with no if_done_out.
  - if_abort_in high in IDLE blocks an IF grant that cycle (MEM may still be granted).
  - MEM accesses are never aborted.
- Undefined: if_abort_in is ignored and IF reads always complete.

## Test plan
- IF word read at 0x1000, RAM bytes 0x13,0x05,0x10,0x00 → ram_a_out steps through 0x1000..0x1003, then if_inst_out = 0x00100513 with if_done_out high exactly one cycle, 5 edges after grant.
- MEM store, len=1, addr 0x2002, wdata 0xAABBCCDD → two write cycles, (0x2002, 0xDD) then (0x2003, 0xCC); mem_done_out one edge after the last write; no write strobe in DONE.
- if_req_in and mem_req_in rise together (MEM byte load at 0x30, RAM byte 0xFF) → MEM served first with mem_rdata_out = 0x000000FF. IF is granted at the edge after MEM's DONE.
- rdy_in low for 3 cycles in the middle of an IF word read → ram_a_out holds and ram_wr_out stays 0; the final word is correct and done arrives 3 cycles late.
- Reset pulse during WRITE at byte 1 → all outputs 0 immediately and no done pulse. After release, a new request is granted normally.
- With MEMCTRL_ABORT_EN, if_abort_in pulsed after byte 1 of an IF read → IDLE at the next edge and no if_done_out. A pending mem_req_in is granted on the following edge.
